strided_address_gen: RTL and testbench
======================================

STRIDED_ADDRESS_GEN -- requirements
Module: strided_address_gen

Interface
REQ-001 Parameter N_DIMS, default N_SUBSCRIPTS, number of nested loop dimensions (1..4).
REQ-002 Parameter NBIT_ADDR, default NBIT_FLAT_ADDR, flat address width.
REQ-003 Parameter NBIT_ITER, default 8, per-dimension iteration-count width.
REQ-004 Port: clk_i  input  1  the single clock of the block.
REQ-005 Port: rst_n_i  input  1  asynchronous active-low reset.
REQ-006 Port: start_i  input  1  single-cycle pulse that starts a sequence.
REQ-007 Port: clear_i  input  1  synchronous abort back to IDLE.
REQ-008 Port: cfg_base_i  input  NBIT_ADDR  base address.
REQ-009 Port: iv_const_i  input  NBIT_IV_CONST  constant offset, zero-extended to NBIT_ADDR.
REQ-010 Port: cfg_bound_i  input  N_DIMS x NBIT_ITER  iteration count per dimension; index 0 is the innermost.
REQ-011 Port: cfg_stride_i  input  N_DIMS x NBIT_ADDR  address stride per dimension.
REQ-012 Port: addr_o  output  NBIT_ADDR  current flat address.
REQ-013 Port: addr_valid_o  output  1  addr_o is valid.
REQ-014 Port: addr_ready_i  input  1  the consumer accepts addr_o.
REQ-015 Port: last_o  output  1  addr_o is the final address of the sequence.
REQ-016 Port: busy_o  output  1  the FSM is not in IDLE.
REQ-017 Port: done_o  output  1  one-cycle pulse after the last handshake.

Function
REQ-018 The FSM SHALL have three states (IDLE, RUN, DONE), with transitions IDLE->RUN on start_i, RUN->DONE on a handshake with last_o=1, and DONE->IDLE unconditionally after one cycle.
REQ-019 On start_i in IDLE, the block SHALL latch cfg_base_i + iv_const_i, all bounds and all strides, and SHALL clear all indices and partial offsets.
REQ-020 addr_valid_o SHALL be high exactly when the FSM is in RUN; the first address appears the cycle after start_i.
REQ-021 addr_o SHALL equal latched_base + sum over d of (idx_d * stride_d), modulo 2^NBIT_ADDR.
REQ-022 The per-dimension partial offsets SHALL be held in registers and updated only by add or subtract, with no multipliers.
REQ-023 A handshake (addr_valid_o & addr_ready_i) SHALL advance the indices like an odometer: idx_0 increments, and when idx_d == bound_d-1 that index wraps to 0 and carries into dimension d+1.
REQ-024 When a dimension wraps, its partial offset SHALL reset to 0 in the same cycle as the carry is applied.
REQ-025 last_o SHALL be high while in RUN when every idx_d == bound_d-1.
REQ-026 A bound of 0 SHALL be treated as 1.
REQ-027 The total number of addresses produced SHALL be the product of the effective bounds.
REQ-028 While addr_valid_o=1 and addr_ready_i=0, addr_o and last_o SHALL hold stable.
REQ-029 start_i SHALL be ignored in RUN and in DONE.
REQ-030 clear_i SHALL force IDLE on the next edge from any state, SHALL take priority over start_i and over a handshake, and SHALL suppress done_o.
REQ-031 done_o SHALL be high only in DONE; busy_o SHALL be high in RUN and in DONE.
REQ-032 Address overflow SHALL wrap silently.
REQ-033 addr_o, addr_valid_o, last_o and done_o SHALL be driven directly from registers.

Reset
REQ-034 While rst_n_i is low, the block SHALL asynchronously go to IDLE with all indices, partial offsets, addr_o and the latched configuration at 0, and with every output low.
REQ-035 Reset asserted mid-sequence SHALL abort the sequence, SHALL NOT pulse done_o, and after release the block SHALL wait for a new start_i.

Structure
REQ-036 The state enum type SHALL be declared in mage_pkg.
REQ-037 The N_SUBSCRIPTS, NBIT_FLAT_ADDR and NBIT_IV_CONST constants SHALL come from mage_pkg.
REQ-038 Per-dimension index and offset logic SHALL be one sub-module, agu_dim_counter (index, partial offset, wrap flag, carry in/out), instantiated N_DIMS times with generate.
REQ-039 The FSM and the final adder tree SHALL reside in the top level.

Verification
REQ-040 N_DIMS=2, base=0x100, iv_const=4, bound={3,2}, stride={1,0x10}, ready held at 1 -> addr_o = 0x104, 0x105, 0x106, 0x114, 0x115, 0x116 on consecutive cycles, last_o with 0x116, then done_o one cycle later.
REQ-041 Same configuration with addr_ready_i toggling 1,0,0,1,... -> the same six addresses in order, each held stable while ready is low, with no skips or repeats.
REQ-042 bound={0,1}, base=0x20, iv_const=0 -> exactly one address, 0x20, with last_o=1, then done_o.
REQ-043 start_i asserted again in RUN, and clear_i asserted after the third handshake -> the second start has no effect; after clear_i, busy_o=0 on the next cycle, no done_o, and a new start restarts at the base.
REQ-044 rst_n_i pulsed low mid-sequence -> all outputs go to 0 immediately; after release, addr_valid_o stays 0 until start_i.
REQ-045 base=0xFFFF_FFF0 (NBIT_ADDR=32), stride_0=0x10, bound_0=2 -> addr_o = 0xFFFF_FFF0, then 0x0000_0000 (wrap).

Source files
------------

// File: rtl/mage_pkg.sv
// rtl/mage_pkg.sv - shared constants and FSM state type for the strided address generator
package mage_pkg;

  localparam int N_SUBSCRIPTS   = 2;
  localparam int NBIT_FLAT_ADDR = 32;
  localparam int NBIT_IV_CONST  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } agu_state_e;

endpackage

// File: rtl/agu_dim_counter.sv
// rtl/agu_dim_counter.sv - one odometer digit: index, partial offset, wrap and carry
module agu_dim_counter #(
  parameter int NBIT_ADDR = 32,
  parameter int NBIT_ITER = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 carry_i,
  input  logic [NBIT_ITER-1:0] bound_i,
  input  logic [NBIT_ADDR-1:0] stride_i,
  output logic [NBIT_ADDR-1:0] offset_next_o,
  output logic                 wrap_next_o,
  output logic                 carry_o
);

  logic [NBIT_ITER-1:0] max_q;
  logic [NBIT_ITER-1:0] idx_q, idx_d;
  logic [NBIT_ADDR-1:0] stride_q;
  logic [NBIT_ADDR-1:0] offset_q, offset_d;
  logic                 wrap;

  assign wrap    = (idx_q == max_q);
  assign carry_o = carry_i & wrap;

  // Offset tracks idx * stride purely by accumulation; a wrap restarts it at zero.
  always_comb begin
    idx_d    = idx_q;
    offset_d = offset_q;
    if (carry_i) begin
      if (wrap) begin
        idx_d    = '0;
        offset_d = '0;
      end else begin
        idx_d    = idx_q + NBIT_ITER'(1);
        offset_d = offset_q + stride_q;
      end
    end
  end

  assign offset_next_o = offset_d;
  assign wrap_next_o   = (idx_d == max_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      max_q    <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      offset_q <= '0;
    end else if (load_i) begin
      // A zero bound behaves like one iteration.
      max_q    <= (bound_i == '0) ? '0 : bound_i - NBIT_ITER'(1);
      stride_q <= stride_i;
      idx_q    <= '0;
      offset_q <= '0;
    end else if (step_i) begin
      idx_q    <= idx_d;
      offset_q <= offset_d;
    end
  end

endmodule

// File: rtl/strided_address_gen.sv
// rtl/strided_address_gen.sv - nested-loop strided address generator with valid/ready output
module strided_address_gen
  import mage_pkg::*;
#(
  parameter int N_DIMS    = N_SUBSCRIPTS,
  parameter int NBIT_ADDR = NBIT_FLAT_ADDR,
  parameter int NBIT_ITER = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               start_i,
  input  logic                               clear_i,
  input  logic [NBIT_ADDR-1:0]               cfg_base_i,
  input  logic [NBIT_IV_CONST-1:0]           iv_const_i,
  input  logic [N_DIMS-1:0][NBIT_ITER-1:0]   cfg_bound_i,
  input  logic [N_DIMS-1:0][NBIT_ADDR-1:0]   cfg_stride_i,
  output logic [NBIT_ADDR-1:0]               addr_o,
  output logic                               addr_valid_o,
  input  logic                               addr_ready_i,
  output logic                               last_o,
  output logic                               busy_o,
  output logic                               done_o
);

  agu_state_e           state_q, state_d;
  logic [NBIT_ADDR-1:0] base_q, base_d;
  logic [NBIT_ADDR-1:0] addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;

  logic                 load, step, hs;
  logic                 start_last;
  logic [NBIT_ADDR-1:0] start_addr, next_addr;
  logic [NBIT_ADDR-1:0] offset_next [N_DIMS];
  logic [N_DIMS-1:0]    wrap_next;
  logic [N_DIMS:0]      carry;

  assign carry[0]   = 1'b1;
  assign hs         = valid_q & addr_ready_i;
  assign start_addr = cfg_base_i + {{(NBIT_ADDR-NBIT_IV_CONST){1'b0}}, iv_const_i};

  for (genvar d = 0; d < N_DIMS; d++) begin : g_dim
    agu_dim_counter #(
      .NBIT_ADDR(NBIT_ADDR),
      .NBIT_ITER(NBIT_ITER)
    ) u_dim (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .load_i       (load),
      .step_i       (step),
      .carry_i      (carry[d]),
      .bound_i      (cfg_bound_i[d]),
      .stride_i     (cfg_stride_i[d]),
      .offset_next_o(offset_next[d]),
      .wrap_next_o  (wrap_next[d]),
      .carry_o      (carry[d+1])
    );
  end

  always_comb begin
    start_last = 1'b1;
    for (int d = 0; d < N_DIMS; d++) begin
      if (cfg_bound_i[d] > NBIT_ITER'(1)) start_last = 1'b0;
    end
  end

  always_comb begin
    next_addr = base_q;
    for (int d = 0; d < N_DIMS; d++) begin
      next_addr = next_addr + offset_next[d];
    end
  end

  // Every output is precomputed into its register, so the consumer sees no comb paths.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            load    = 1'b1;
            state_d = ST_RUN;
            base_d  = start_addr;
            addr_d  = start_addr;
            valid_d = 1'b1;
            last_d  = start_last;
          end
        end
        ST_RUN: begin
          if (hs) begin
            step = 1'b1;
            // Carry out of the outermost digit means the odometer rolled over.
            if (carry[N_DIMS]) begin
              state_d = ST_DONE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              addr_d = next_addr;
              last_d = &wrap_next;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = valid_q;
  assign last_o       = last_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_strided_address_gen.sv
// tb/tb_strided_address_gen.sv - directed self-checking bench for strided_address_gen
module tb_strided_address_gen;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, clear, ready;
  logic [31:0]      base;
  logic [7:0]       iv;
  logic [1:0][7:0]  bound;
  logic [1:0][31:0] stride;
  logic [31:0]      addr;
  logic             valid, last, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  strided_address_gen dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .clear_i     (clear),
    .cfg_base_i  (base),
    .iv_const_i  (iv),
    .cfg_bound_i (bound),
    .cfg_stride_i(stride),
    .addr_o      (addr),
    .addr_valid_o(valid),
    .addr_ready_i(ready),
    .last_o      (last),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic cfg_std();
    base = 32'h100; iv = 8'd4;
    bound[0] = 8'd3; bound[1] = 8'd2;
    stride[0] = 32'h1; stride[1] = 32'h10;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; clear = 0; ready = 0;
    base = 0; iv = 0; bound = '0; stride = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({addr, valid, last, busy, done} !== 36'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h required 0", {addr, valid, last, busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({valid, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL reset_idle: got %b required 000", {valid, busy, done});
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp [6] = '{32'h104, 32'h105, 32'h106, 32'h114, 32'h115, 32'h116};
    cfg_std(); ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (addr !== exp[i] || valid !== 1'b1 || last !== (i == 5) || done !== 1'b0) begin
        n_err++; $display("FAIL basic_addr%0d: got addr=%h v=%b l=%b d=%b required addr=%h v=1 l=%b d=0",
                          i, addr, valid, last, done, exp[i], (i == 5));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL basic_done: got v=%b d=%b b=%b required v=0 d=1 b=1", valid, done, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_idle: got d=%b b=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [6] = '{32'h104, 32'h105, 32'h106, 32'h114, 32'h115, 32'h116};
    int idx = 0;
    int k = 0;
    cfg_std(); ready = 1'b0;
    pulse_start();
    while (idx < 6 && k < 40) begin
      ready = (k % 3 == 0);
      n_cmp++;
      if (valid !== 1'b1 || addr !== exp[idx] || last !== (idx == 5)) begin
        n_err++; $display("FAIL bp_addr%0d_cyc%0d: got addr=%h v=%b l=%b required addr=%h v=1 l=%b",
                          idx, k, addr, valid, last, exp[idx], (idx == 5));
      end
      if (ready) idx++;
      k++;
      @(negedge clk);
    end
    ready = 1'b1;
    n_cmp++;
    if (idx !== 6) begin
      n_err++; $display("FAIL bp_timeout: got %0d addresses required 6", idx);
    end
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_err++; $display("FAIL bp_done: got d=%b v=%b required d=1 v=0", done, valid);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    base = 32'h20; iv = 8'd0;
    bound[0] = 8'd0; bound[1] = 8'd1;
    stride[0] = 32'h4; stride[1] = 32'h40;
    ready = 1'b1;
    pulse_start();
    n_cmp++;
    if (addr !== 32'h20 || valid !== 1'b1 || last !== 1'b1) begin
      n_err++; $display("FAIL single_addr: got addr=%h v=%b l=%b required addr=20 v=1 l=1", addr, valid, last);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_err++; $display("FAIL single_done: got d=%b v=%b required d=1 v=0", done, valid);
    end
    @(negedge clk);
  endtask

  task automatic test_start_clear();
    logic [31:0] exp [4] = '{32'h104, 32'h105, 32'h106, 32'h114};
    cfg_std(); ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      start = (i == 0);
      clear = (i == 3);
      if (i == 3) start = 1'b1;
      n_cmp++;
      if (addr !== exp[i] || valid !== 1'b1) begin
        n_err++; $display("FAIL sc_addr%0d: got addr=%h v=%b required addr=%h v=1", i, addr, valid, exp[i]);
      end
      @(negedge clk);
    end
    start = 1'b0; clear = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL sc_cleared: got b=%b v=%b d=%b required 000", busy, valid, done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL sc_no_done: got d=%b b=%b required 0 0", done, busy);
    end
    pulse_start();
    n_cmp++;
    if (addr !== 32'h104 || valid !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL sc_restart: got addr=%h v=%b b=%b required addr=104 v=1 b=1", addr, valid, busy);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    cfg_std(); ready = 1'b1;
    pulse_start();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({addr, valid, last, busy, done} !== 36'h0) begin
      n_err++; $display("FAIL rst_mid_outputs: got %h required 0", {addr, valid, last, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_wait: got v=%b d=%b b=%b required 000", valid, done, busy);
    end
  endtask

  task automatic test_wrap();
    base = 32'hFFFF_FFF0; iv = 8'd0;
    bound[0] = 8'd2; bound[1] = 8'd1;
    stride[0] = 32'h10; stride[1] = 32'h0;
    ready = 1'b1;
    pulse_start();
    n_cmp++;
    if (addr !== 32'hFFFF_FFF0 || last !== 1'b0) begin
      n_err++; $display("FAIL wrap_first: got addr=%h l=%b required addr=fffffff0 l=0", addr, last);
    end
    @(negedge clk);
    n_cmp++;
    if (addr !== 32'h0000_0000 || last !== 1'b1 || valid !== 1'b1) begin
      n_err++; $display("FAIL wrap_second: got addr=%h l=%b v=%b required addr=0 l=1 v=1", addr, last, valid);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL wrap_done: got d=%b required 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_start_clear();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
